// File: rtl/md_sched_ctrl_pkg.sv
// md_sched_ctrl_pkg: shared MD-unit op encodings, FSM states and default latencies.
// Divider support is compiled in only when MD_SCHED_DIV_EN is defined.
package md_sched_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_RUN,
        ST_DIV_RUN
    } state_t;

    localparam int DEF_MULT_LAT = 5;
    localparam int DEF_DIV_LAT  = 10;

    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b ? a : b) + 1);
    endfunction

endpackage

// File: rtl/md_sched_ctrl_if.sv
// md_sched_ctrl_if: EX/ID-stage request and HI/LO result bundle of the MD scheduler.
interface md_sched_ctrl_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_d;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;

    modport master (
        output start, op, rs_val, rt_val, md_use_d,
        input  busy, stall, hi, lo, done
    );

    modport slave (
        input  start, op, rs_val, rt_val, md_use_d,
        output busy, stall, hi, lo, done
    );

endinterface

// File: rtl/md_sched_ctrl_arith.sv
// md_arith: combinational MULT/MULTU (and DIV/DIVU with MD_SCHED_DIV_EN) on latched operands.
// res packs {hi, lo}; division returns {remainder, quotient}.
module md_arith
    import md_sched_ctrl_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [63:0] res,
    output logic        div_zero
);

    logic        sgn;
    logic [63:0] prod;

    assign sgn  = (op == OP_MULT) || (op == OP_DIV);
    assign prod = (sgn ? {{32{a[31]}}, a} : {32'b0, a}) * (sgn ? {{32{b[31]}}, b} : {32'b0, b});

`ifdef MD_SCHED_DIV_EN
    logic        is_div;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;

    // Magnitude division with sign fix-up; 0x80000000 / -1 wraps to 0x80000000 naturally.
    assign is_div   = (op == OP_DIV) || (op == OP_DIVU);
    assign neg_r    = sgn & a[31];
    assign neg_q    = sgn & (a[31] ^ b[31]);
    assign ma       = neg_r ? -a : a;
    assign mb       = (sgn & b[31]) ? -b : b;
    assign q        = (mb == '0) ? '0 : ma / mb;
    assign r        = (mb == '0) ? '0 : ma % mb;
    assign div_zero = is_div & (b == '0);
    assign res      = is_div ? {(neg_r ? -r : r), (neg_q ? -q : q)} : prod;
`else
    assign div_zero = 1'b0;
    assign res      = prod;
`endif

endmodule

// File: rtl/md_sched_ctrl.sv
// md_sched_ctrl: multi-cycle MULT/DIV scheduler owning HI/LO, with pipeline stall generation.
// DIV/DIVU are accepted only when MD_SCHED_DIV_EN is defined; otherwise they act as reserved ops.
module md_sched_ctrl
    import md_sched_ctrl_pkg::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT
) (
    input  logic           clk,
    input  logic           reset,
    md_sched_ctrl_if.slave bus
);

    localparam int CW = cnt_width(MULT_LAT, DIV_LAT);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   a;
    logic [31:0]   b;
    logic [2:0]    op_l;
    logic [31:0]   hi;
    logic [31:0]   lo;
    logic          done;
    logic          busy;
    logic          is_mul;
    logic [63:0]   res;
    logic          div_zero;

    md_arith u_arith (
        .a        (a),
        .b        (b),
        .op       (op_l),
        .res      (res),
        .div_zero (div_zero)
    );

    assign is_mul    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign busy      = state != ST_IDLE;
    assign bus.busy  = busy;
    assign bus.stall = bus.md_use_d & (busy | bus.start);
    assign bus.hi    = hi;
    assign bus.lo    = lo;
    assign bus.done  = done;

`ifdef MD_SCHED_DIV_EN
    logic is_div;
    assign is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            a     <= '0;
            b     <= '0;
            op_l  <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (is_mul) begin
                            a     <= bus.rs_val;
                            b     <= bus.rt_val;
                            op_l  <= bus.op;
                            cnt   <= CW'(MULT_LAT);
                            state <= ST_MUL_RUN;
                        end
`ifdef MD_SCHED_DIV_EN
                        else if (is_div) begin
                            a     <= bus.rs_val;
                            b     <= bus.rt_val;
                            op_l  <= bus.op;
                            cnt   <= CW'(DIV_LAT);
                            state <= ST_DIV_RUN;
                        end
`endif
                        else if (bus.op == OP_MTHI) hi <= bus.rs_val;
                        else if (bus.op == OP_MTLO) lo <= bus.rs_val;
                    end
                end
                default: begin
                    cnt <= cnt - 1'b1;
                    // Last busy cycle: commit (unless divide-by-zero) and flag done for the next cycle.
                    if (cnt == CW'(1)) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                        if (!div_zero) {hi, lo} <= res;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_sched_ctrl.sv
// tb_md_sched_ctrl: scoreboard bench for md_sched_ctrl (MD_SCHED_DIV_EN selects divider expectations).
module tb_md_sched_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [63:0] ref_hl = '0;
    logic [63:0] sb[$];

`ifdef MD_SCHED_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    md_sched_ctrl_if bus ();

    md_sched_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] cur);
        longint sa;
        longint sb_v;
        logic [63:0] r;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        r    = cur;
        case (op)
            3'd0: r = 64'(sa * sb_v);
            3'd1: r = {32'b0, a} * {32'b0, b};
            3'd2: if (DIV_ON && b != 0) r = {32'(sa % sb_v), 32'(sa / sb_v)};
            3'd3: if (DIV_ON && b != 0) r = {a % b, a / b};
            3'd4: r = {a, cur[31:0]};
            3'd5: r = {cur[63:32], a};
            default: ;
        endcase
        return r;
    endfunction

    function automatic int lat_of(input logic [2:0] op);
        return (op < 3'd2) ? 5 : (op < 3'd4 && DIV_ON) ? 10 : 0;
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          output int bc, output logic [63:0] hl, output logic d0, output logic d1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = op;
        bus.rs_val = rs;
        bus.rt_val = rt;
        @(negedge clk);
        bus.start = 1'b0;
        bus.rs_val = ~rs;
        bus.rt_val = ~rt;
        bc = 0;
        while (bus.busy && bc < 64) begin
            bc++;
            @(negedge clk);
        end
        hl = {bus.hi, bus.lo};
        d0 = bus.done;
        @(negedge clk);
        d1 = bus.done;
    endtask

    task automatic test_reset();
        bus.md_use_d = 1'b1;
        #1;
        checks += 5;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        if (bus.hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
        if (bus.lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
        if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
        bus.md_use_d = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_ops(input string name, input logic [2:0] ops[], input logic [31:0] rss[],
                            input logic [31:0] rts[], input logic [63:0] exps[], input bit use_exp);
        int bc;
        logic [63:0] hl;
        logic [63:0] e;
        logic d0;
        logic d1;
        foreach (ops[i]) begin
            e = use_exp ? exps[i] : model(ops[i], rss[i], rts[i], ref_hl);
            sb.push_back(e);
            run_op(ops[i], rss[i], rts[i], bc, hl, d0, d1);
            e = sb.pop_front();
            ref_hl = e;
            checks += 4;
            if (bc !== lat_of(ops[i])) begin failures++; $display("FAIL %s[%0d]_busy_cycles got=%0d exp=%0d", name, i, bc, lat_of(ops[i])); end
            if (hl !== e) begin failures++; $display("FAIL %s[%0d]_hilo got=%h exp=%h", name, i, hl, e); end
            if (d0 !== (lat_of(ops[i]) != 0)) begin failures++; $display("FAIL %s[%0d]_done got=%b exp=%b", name, i, d0, lat_of(ops[i]) != 0); end
            if (d1 !== 1'b0) begin failures++; $display("FAIL %s[%0d]_done_width got=%b exp=0", name, i, d1); end
        end
    endtask

    task automatic test_stall_ignore();
        int n;
        logic [63:0] e;
        bus.md_use_d = 1'b1;
        e = model(3'd0, 32'd3, 32'd4, ref_hl);
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.rs_val = 32'd3; bus.rt_val = 32'd4;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin failures++; $display("FAIL stall_start_cycle got=%b exp=1", bus.stall); end
        @(negedge clk);
        bus.op = 3'd1; bus.rs_val = 32'd7; bus.rt_val = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (bus.busy && n < 64) begin
            checks++;
            if (bus.stall !== 1'b1) begin failures++; $display("FAIL stall_busy_cycle%0d got=%b exp=1", n, bus.stall); end
            n++;
            @(negedge clk);
        end
        e = sb.pop_front();
        ref_hl = e;
        checks += 3;
        if (n !== 5) begin failures++; $display("FAIL stall_busy_cycles got=%0d exp=5", n); end
        if (bus.stall !== 1'b0) begin failures++; $display("FAIL stall_release got=%b exp=0", bus.stall); end
        if ({bus.hi, bus.lo} !== e) begin failures++; $display("FAIL stall_ignore_hilo got=%h exp=%h", {bus.hi, bus.lo}, e); end
        bus.md_use_d = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [2:0] op;
        op = DIV_ON ? 3'd2 : 3'd0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        ref_hl = '0;
        #1;
        checks += 3;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        if ({bus.hi, bus.lo} !== ref_hl) begin failures++; $display("FAIL abort_hilo got=%h exp=%h", {bus.hi, bus.lo}, ref_hl); end
        if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", bus.done); end
        repeat (12) @(negedge clk);
        checks++;
        if ({bus.hi, bus.lo} !== ref_hl) begin failures++; $display("FAIL abort_no_commit got=%h exp=%h", {bus.hi, bus.lo}, ref_hl); end
        reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops[] = new[6];
        logic [31:0] rss[] = new[6];
        logic [31:0] rts[] = new[6];
        logic [63:0] exps[] = new[6];
        foreach (ops[i]) begin
            ops[i] = 3'($urandom_range(0, 1));
            rss[i] = $urandom;
            rts[i] = $urandom;
        end
        test_ops("b2b", ops, rss, rts, exps, 1'b0);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = '0; bus.rs_val = '0; bus.rt_val = '0; bus.md_use_d = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_ops("mult", '{3'd0, 3'd1}, '{32'hFFFFFFFE, 32'hFFFFFFFF}, '{32'd3, 32'd2},
                 '{64'hFFFFFFFF_FFFFFFFA, 64'h00000001_FFFFFFFE}, 1'b1);
        test_ops("div", '{3'd2, 3'd2, 3'd2, 3'd3}, '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'd100},
                 '{32'd2, 32'd0, 32'hFFFFFFFF, 32'd7}, '{64'h0, 64'h0, 64'h0, 64'h0}, 1'b0);
        test_ops("mt", '{3'd4, 3'd5, 3'd6, 3'd7}, '{32'h12345678, 32'h9ABCDEF0, 32'h5, 32'h6},
                 '{32'h0, 32'h0, 32'h0, 32'h0}, '{64'h12345678_00000000, 64'h0, 64'h0, 64'h0}, 1'b0);
        test_stall_ignore();
        test_back_to_back();
        test_reset_abort();
        test_ops("after_reset", '{3'd1}, '{32'h0000FFFF}, '{32'h00010001}, '{64'h00000000_FFFFFFFF}, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_sched_ctrl.md
MD_SCHED_CTRL -- requirements
Module: md_sched_ctrl

Interface
REQ-001 SHALL have parameter MULT_LAT, default 5: busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_LAT, default 10: busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  EX-stage MD instruction valid, already qualified against flush.
REQ-006 SHALL have port op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6/7 reserved, no effect.
REQ-007 SHALL have port rs_val  in  32  forwarded rs operand.
REQ-008 SHALL have port rt_val  in  32  forwarded rt operand.
REQ-009 SHALL have port md_use_d  in  1  ID-stage instruction is any MD-class op, including MFHI/MFLO.
REQ-010 SHALL have port busy  out  1  multi-cycle operation in flight.
REQ-011 SHALL have port stall  out  1  freeze request to PC/IF/ID registers.
REQ-012 SHALL have port hi  out  32  HI register.
REQ-013 SHALL have port lo  out  32  LO register.
REQ-014 SHALL have port done  out  1  one-cycle pulse in the cycle after a HI/LO commit.

Function
REQ-015 SHALL implement states IDLE, MUL_RUN, DIV_RUN plus a down-counter wide enough for max(MULT_LAT, DIV_LAT).
REQ-016 IDLE with start and op 0/1 SHALL, at the next edge, latch rs_val/rt_val, load the counter with MULT_LAT, and enter MUL_RUN.
REQ-017 IDLE with start and op 2/3 SHALL do the same with DIV_LAT and enter DIV_RUN.
REQ-018 Each edge in MUL_RUN/DIV_RUN SHALL decrement the counter.
REQ-019 In MUL_RUN/DIV_RUN, the edge at which the counter equals 1 SHALL write HI/LO, return to IDLE, and assert done for the following cycle.
REQ-020 busy SHALL be high exactly LAT cycles after the capturing edge; the new hi/lo SHALL be visible in the first cycle busy is low.
REQ-021 start with MTHI/MTLO in IDLE SHALL write rs_val to hi/lo at the next edge, with no busy and no done.
REQ-022 start while busy SHALL be ignored; state, counter and operands are unchanged.
REQ-023 stall SHALL equal md_use_d & (busy | start), combinationally.
REQ-024 MULT/MULTU SHALL produce a 64-bit signed/unsigned product: hi = bits 63:32, lo = bits 31:0.
REQ-025 DIV/DIVU SHALL set lo = quotient (truncated toward zero) and hi = remainder (sign of dividend).
REQ-026 Division by zero SHALL still run the full latency but leave hi/lo unchanged; done still pulses.
REQ-027 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-028 Operands SHALL come only from the latched copies; input changes during busy SHALL have no effect.

Reset
REQ-029 reset low SHALL immediately force IDLE, counter=0, busy=0, done=0, hi=0, lo=0, and latched operands=0, regardless of the clock.
REQ-030 reset asserted mid-operation SHALL abort it with no HI/LO commit.
REQ-031 After reset deassertion, the first start SHALL be accepted at the next edge.

Configuration
REQ-032 With macro MD_SCHED_DIV_EN defined, DIV/DIVU SHALL behave per REQ-017/025/026/027.
REQ-033 Without MD_SCHED_DIV_EN, op 2/3 SHALL be treated as reserved (no busy, no hi/lo change), and no divider logic SHALL be synthesized.

Structure
REQ-034 Op encodings, state encodings and default latencies SHALL live in the shared CPU parameter header.
REQ-035 The arithmetic SHALL be a combinational sub-module md_arith (inputs: latched operands, op; outputs: 64-bit result and a div-by-zero flag); md_sched_ctrl SHALL hold only the FSM, counter and registers.

Verification
REQ-036 MULT rs=0xFFFFFFFE, rt=3 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
REQ-037 MULTU rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-038 DIV rs=0xFFFFFFF9 (-7), rt=2 -> 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; same run with rt=0 -> hi/lo keep their prior values.
REQ-039 md_use_d=1 held through a MULT -> stall high from the start cycle through the last busy cycle, then low; a second start during busy is ignored.
REQ-040 MTHI rs=0x12345678 -> hi=0x12345678 next edge with busy=0; reset pulsed low in the 3rd cycle of a DIV -> hi/lo=0, busy=0 immediately.
REQ-041 Build without MD_SCHED_DIV_EN, issue DIV -> busy stays 0 and hi/lo are unchanged.
